// File: rtl/ata_sector_bridge_if.sv
// Host-side handshakes of the ATA sector bridge: command, write-word and read-word channels.
interface ata_sector_bridge_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_lba;
  logic [7:0]  cmd_count;
  logic [15:0] wr_word;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] rd_word;
  logic        rd_valid;
  logic        rd_ready;

  // Host side: issues commands, supplies write words, consumes read words.
  modport master (
    output cmd_valid, cmd_write, cmd_lba, cmd_count, wr_word, wr_valid, rd_ready,
    input  cmd_ready, wr_ready, rd_word, rd_valid
  );

  // Bridge side.
  modport slave (
    input  cmd_valid, cmd_write, cmd_lba, cmd_count, wr_word, wr_valid, rd_ready,
    output cmd_ready, wr_ready, rd_word, rd_valid
  );
endinterface

// File: rtl/ata_sector_bridge.sv
// Sector-transfer engine between 16-bit host PIO words and a byte-wide async sector buffer.
// Every command is range-checked against the buffer before any RAM cycle is issued.
module ata_sector_bridge #(
  parameter int unsigned AddrW       = 33,
  parameter int unsigned SectorBytes = 512,
  parameter int unsigned MemBytes    = 393216
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  ata_sector_bridge_if.slave host,
  output logic [AddrW-1:0] ram_addr_o,
  inout  wire  [7:0]       ram_data_io,
  output logic             ram_cs_o,
  output logic             ram_we_o,
  output logic             ram_re_o,
  output logic             busy_o,
  output logic             sect_done_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int unsigned SectShift = $clog2(SectorBytes);
  localparam int unsigned CalcW     = 42;

  typedef enum logic [3:0] {
    StIdle, StCheck, StErr, StWrWait, StWrLo, StWrHi, StRdLo, StRdHi, StRdOut, StDone
  } state_e;

  state_e             state_q;
  logic               write_q;
  logic [31:0]        lba_q;
  logic [7:0]         count_q;
  logic [AddrW-1:0]   addr_q;
  logic [CalcW-1:0]   left_q;
  logic [15:0]        word_q;
  logic [15:0]        rd_word_q;
  logic [AddrW-1:0]   ram_addr_q;
  logic [7:0]         ram_wdata_q;
  logic               ram_cs_q, ram_we_q, ram_re_q;
  logic               sect_done_q, done_q, err_q;

  logic [CalcW-1:0]   n_sect, start_b, total_b, end_b;
  logic [AddrW-1:0]   addr_nxt;
  logic               sect_end, last_word;

  // Range arithmetic on the latched command and per-word address bookkeeping.
  always_comb begin
    n_sect    = (count_q == 8'd0) ? CalcW'(256) : CalcW'(count_q);
    start_b   = CalcW'(lba_q) << SectShift;
    total_b   = n_sect << SectShift;
    end_b     = start_b + total_b;
    addr_nxt  = addr_q + AddrW'(2);
    sect_end  = (addr_nxt[SectShift-1:0] == '0);
    last_word = (left_q == CalcW'(2));
  end

  // Main FSM; RAM strobes, address and write byte are loaded together on each transition.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      lba_q       <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      left_q      <= '0;
      word_q      <= '0;
      rd_word_q   <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      sect_done_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sect_done_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (host.cmd_valid) begin
            write_q <= host.cmd_write;
            lba_q   <= host.cmd_lba;
            count_q <= host.cmd_count;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (end_b > CalcW'(MemBytes)) begin
            err_q   <= 1'b1;
            state_q <= StErr;
          end else begin
            addr_q <= AddrW'(start_b);
            left_q <= total_b;
            if (write_q) begin
              state_q <= StWrWait;
            end else begin
              ram_cs_q   <= 1'b1;
              ram_re_q   <= 1'b1;
              ram_addr_q <= AddrW'(start_b);
              state_q    <= StRdLo;
            end
          end
        end
        StErr: state_q <= StIdle;
        StWrWait: begin
          if (host.wr_valid) begin
            word_q      <= host.wr_word;
            ram_cs_q    <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= addr_q;
            ram_wdata_q <= host.wr_word[7:0];
            state_q     <= StWrLo;
          end
        end
        StWrLo: begin
          ram_addr_q  <= addr_q + AddrW'(1);
          ram_wdata_q <= word_q[15:8];
          state_q     <= StWrHi;
        end
        StWrHi: begin
          ram_cs_q    <= 1'b0;
          ram_we_q    <= 1'b0;
          addr_q      <= addr_nxt;
          left_q      <= left_q - CalcW'(2);
          sect_done_q <= sect_end;
          state_q     <= last_word ? StDone : StWrWait;
        end
        StRdLo: begin
          rd_word_q[7:0] <= ram_data_io;
          ram_addr_q     <= addr_q + AddrW'(1);
          state_q        <= StRdHi;
        end
        StRdHi: begin
          rd_word_q[15:8] <= ram_data_io;
          ram_cs_q        <= 1'b0;
          ram_re_q        <= 1'b0;
          state_q         <= StRdOut;
        end
        StRdOut: begin
          if (host.rd_ready) begin
            addr_q      <= addr_nxt;
            left_q      <= left_q - CalcW'(2);
            sect_done_q <= sect_end;
            if (last_word) begin
              state_q <= StDone;
            end else begin
              ram_cs_q   <= 1'b1;
              ram_re_q   <= 1'b1;
              ram_addr_q <= addr_nxt;
              state_q    <= StRdLo;
            end
          end
        end
        StDone: begin
          // done lands in the cycle after the final sect_done, i.e. first IDLE cycle.
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign host.cmd_ready = (state_q == StIdle);
  assign host.wr_ready  = (state_q == StWrWait);
  assign host.rd_valid  = (state_q == StRdOut);
  assign host.rd_word   = rd_word_q;

  assign ram_addr_o  = ram_addr_q;
  assign ram_cs_o    = ram_cs_q;
  assign ram_we_o    = ram_we_q;
  assign ram_re_o    = ram_re_q;
  assign ram_data_io = ram_we_q ? ram_wdata_q : 8'bz;

  assign busy_o      = (state_q != StIdle);
  assign sect_done_o = sect_done_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ata_sector_bridge.sv
// Directed plus randomized bench for ata_sector_bridge against a byte-array reference model.
module tb_ata_sector_bridge;
  localparam int unsigned AddrW    = 33;
  localparam int          MemBytes = 393216;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  ata_sector_bridge_if bif ();
  logic [AddrW-1:0] ram_addr;
  wire  [7:0]       ram_data;
  logic ram_cs, ram_we, ram_re, busy, sect_done, done, err;

  ata_sector_bridge #(
    .AddrW       (AddrW),
    .SectorBytes (512),
    .MemBytes    (MemBytes)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .host        (bif),
    .ram_addr_o  (ram_addr),
    .ram_data_io (ram_data),
    .ram_cs_o    (ram_cs),
    .ram_we_o    (ram_we),
    .ram_re_o    (ram_re),
    .busy_o      (busy),
    .sect_done_o (sect_done),
    .done_o      (done),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sector buffer RAM (async read) and the reference image of what it should hold.
  logic [7:0] mem     [0:MemBytes-1];
  logic [7:0] ref_mem [0:MemBytes-1];
  bit         ram_oob = 1'b0;

  assign ram_data = (ram_cs && ram_re && !ram_we && (ram_addr < AddrW'(MemBytes))) ?
                    mem[ram_addr[18:0]] : 8'bz;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < MemBytes; i++) mem[i] <= 8'h00;
    end else if (ram_cs && ram_we) begin
      if (ram_addr < AddrW'(MemBytes)) mem[ram_addr[18:0]] <= ram_data;
      else ram_oob <= 1'b1;
    end
  end

  int sect_cnt = 0, done_cnt = 0, err_cnt = 0, cs_cnt = 0, bad_ready = 0;
  always @(posedge clk) begin
    #1;
    if (sect_done) sect_cnt <= sect_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (ram_cs) cs_cnt <= cs_cnt + 1;
    if (bif.cmd_ready && busy) bad_ready <= bad_ready + 1;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_reject(input logic [31:0] lba, input logic [7:0] cnt);
    longint n;
    n = (cnt == 8'd0) ? 256 : longint'(cnt);
    return (longint'(lba) * 512 + n * 512) > longint'(MemBytes);
  endfunction

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic issue_cmd(input bit wr, input logic [31:0] lba, input logic [7:0] cnt,
                           output int acc);
    int n;
    bif.cmd_write = wr; bif.cmd_lba = lba; bif.cmd_count = cnt; bif.cmd_valid = 1'b1;
    n = 0;
    while (!bif.cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_accept_in_budget", 64'(n < 100), 64'(1));
    acc = cyc + 1;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 50) begin @(negedge clk); n++; end
    chk("done_pulse_count", 64'(done_cnt - d0), 64'(1));
    chk("idle_after_done", 64'(busy), 64'(0));
  endtask

  task automatic reset_pulse();
    int d0;
    d0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_strobes_low", 64'({ram_cs, ram_we, ram_re}), 64'(0));
    chk("rst_status_low", 64'({busy, bif.rd_valid, bif.wr_ready, sect_done, err}), 64'(0));
    rst_n = 1'b1;
    bif.wr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_no_done", 64'(done_cnt - d0), 64'(0));
  endtask

  task automatic do_write(input logic [31:0] lba, input logic [7:0] cnt, input bit pattern,
                          input bit gaps, input int abort_at);
    int nw, acc, s0, d0, n, got, base, bad;
    logic [15:0] w[$];
    bit aborted;
    nw = ((cnt == 8'd0) ? 256 : int'(cnt)) * 256;
    base = int'(lba) * 512;
    for (int i = 0; i < nw; i++) w.push_back(pattern ? 16'(16'h0100 + 2 * i) : 16'($urandom));
    s0 = sect_cnt; d0 = done_cnt; got = 0; aborted = 1'b0;
    issue_cmd(1'b1, lba, cnt, acc);
    for (int i = 0; i < nw; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin bif.wr_valid = 1'b0; @(negedge clk); end
      bif.wr_valid = 1'b1; bif.wr_word = w[i];
      n = 0;
      while (!bif.wr_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) break;
      got++;
      if (i == abort_at) begin
        @(negedge clk); @(negedge clk);
        chk("abort_in_wr_hi", {30'd0, ram_we, ram_addr}, {30'd0, 1'b1, AddrW'(base + 2 * i + 1)});
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bif.wr_valid = 1'b0;
    if (aborted) begin
      reset_pulse();
      bad = 0;
      for (int j = 0; j < abort_at; j++)
        if (mem[base + 2 * j] !== w[j][7:0] || mem[base + 2 * j + 1] !== w[j][15:8]) bad++;
      chk("rst_bytes_retained", 64'(bad), 64'(0));
      // Both bytes of the interrupted word reached the RAM before the reset edge.
      for (int j = 0; j <= abort_at; j++) begin
        ref_mem[base + 2 * j] = w[j][7:0]; ref_mem[base + 2 * j + 1] = w[j][15:8];
      end
      return;
    end
    chk("wr_words_accepted", 64'(got), 64'(nw));
    wait_done(d0);
    chk("wr_sect_done_count", 64'(sect_cnt - s0), 64'(nw / 256));
    for (int j = 0; j < got; j++) begin
      ref_mem[base + 2 * j] = w[j][7:0]; ref_mem[base + 2 * j + 1] = w[j][15:8];
    end
  endtask

  task automatic stream_read(input logic [31:0] lba, input int limit, input int stall_at,
                             input int acc, output int lat, output logic [15:0] first_w,
                             output logic [15:0] last_w, output int got);
    int base, n, bad, sbad;
    logic [15:0] exp_w, hold;
    base = int'(lba) * 512; bad = 0; got = 0; lat = -1; first_w = '0; last_w = '0;
    for (int i = 0; i < limit; i++) begin
      n = 0;
      while (!bif.rd_valid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) break;
      if (i == 0) begin lat = cyc - acc; first_w = bif.rd_word; end
      last_w = bif.rd_word;
      exp_w = {ref_mem[base + 2 * i + 1], ref_mem[base + 2 * i]};
      if (bif.rd_word !== exp_w) bad++;
      if (i == stall_at) begin
        bif.rd_ready = 1'b0; hold = bif.rd_word; sbad = 0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (!bif.rd_valid || bif.rd_word !== hold || ram_cs) sbad++;
        end
        chk("rd_stall_hold", 64'(sbad), 64'(0));
        bif.rd_ready = 1'b1;
      end
      got++;
      @(negedge clk);
    end
    chk("rd_data_bad_words", 64'(bad), 64'(0));
  endtask

  task automatic do_read(input logic [31:0] lba, input logic [7:0] cnt, input int stall_at,
                         output int lat, output logic [15:0] first_w, output logic [15:0] last_w);
    int nw, acc, s0, d0, got;
    nw = ((cnt == 8'd0) ? 256 : int'(cnt)) * 256;
    s0 = sect_cnt; d0 = done_cnt;
    issue_cmd(1'b0, lba, cnt, acc);
    stream_read(lba, nw, stall_at, acc, lat, first_w, last_w, got);
    chk("rd_words_delivered", 64'(got), 64'(nw));
    wait_done(d0);
    chk("rd_sect_done_count", 64'(sect_cnt - s0), 64'(nw / 256));
  endtask

  task automatic do_reject(input logic [31:0] lba, input logic [7:0] cnt);
    int acc, cs0, e0;
    cs0 = cs_cnt; e0 = err_cnt;
    issue_cmd(1'b0, lba, cnt, acc);
    chk("rej_check_not_ready", 64'(bif.cmd_ready), 64'(0));
    @(negedge clk);
    chk("rej_err_pulse", 64'({err, bif.cmd_ready}), 64'(2'b10));
    @(negedge clk);
    chk("rej_ready_again", 64'({err, bif.cmd_ready}), 64'(2'b01));
    chk("rej_err_count", 64'(err_cnt - e0), 64'(1));
    chk("rej_no_ram_cs", 64'(cs_cnt - cs0), 64'(0));
  endtask

  initial begin : stim
    int lat, acc, got, e0, s0, d0, n;
    logic [15:0] fw, lw;
    logic [31:0] lba;
    logic [7:0]  cnt;

    for (int i = 0; i < MemBytes; i++) ref_mem[i] = 8'h00;
    rst_n = 1'b0;
    bif.cmd_valid = 1'b0; bif.cmd_write = 1'b0; bif.cmd_lba = '0; bif.cmd_count = '0;
    bif.wr_valid = 1'b0; bif.wr_word = '0; bif.rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs_low",
        64'({ram_cs, ram_we, ram_re, busy, bif.rd_valid, bif.wr_ready, done, err, sect_done}),
        64'(0));
    chk("reset_addr_zero", 64'(ram_addr), 64'(0));
    chk("reset_cmd_ready", 64'(bif.cmd_ready), 64'(1));
    rst_n = 1'b1;
    @(negedge clk);

    // Sector 0 with the 0x0100+2i pattern, wr_valid held high.
    do_write(32'd0, 8'd1, 1'b1, 1'b0, -1);
    chk("ram_bytes_0_3", 64'({mem[3], mem[2], mem[1], mem[0]}), 64'(32'h0102_0100));

    do_read(32'd0, 8'd1, -1, lat, fw, lw);
    chk("rd_first_word", 64'(fw), 64'(16'h0100));
    chk("rd_last_word", 64'(lw), 64'(16'h02FE));
    chk("rd_first_latency", 64'(lat), 64'(3));

    // Backpressure at word 5.
    do_read(32'd0, 8'd1, 5, lat, fw, lw);

    // Range boundaries, including operands that would wrap at 32 or 33 bits.
    do_reject(32'd767, 8'd2);
    do_reject(32'd513, 8'd0);
    do_reject(32'h0080_0000, 8'd1);
    do_reject(32'h0100_0000, 8'd1);
    do_reject(32'hFFFF_FFFF, 8'd0);

    // Last sector of the buffer.
    do_write(32'd767, 8'd1, 1'b0, 1'b1, -1);
    do_read(32'd767, 8'd1, $urandom_range(0, 255), lat, fw, lw);

    // Exact-fit 256-sector commands: stream two sectors, then abort.
    e0 = err_cnt; s0 = sect_cnt;
    issue_cmd(1'b0, 32'd0, 8'd0, acc);
    stream_read(32'd0, 512, -1, acc, lat, fw, lw, got);
    chk("cnt0_words", 64'(got), 64'(512));
    chk("cnt0_sect_done", 64'(sect_cnt - s0), 64'(2));
    chk("cnt0_still_busy", 64'(busy), 64'(1));
    reset_pulse();
    issue_cmd(1'b0, 32'd512, 8'd0, acc);
    stream_read(32'd512, 1, -1, acc, lat, fw, lw, got);
    chk("fit_end_latency", 64'(lat), 64'(3));
    chk("fit_no_err", 64'(err_cnt - e0), 64'(0));
    reset_pulse();

    // Reset during the high-byte write of word 10.
    do_write(32'd0, 8'd1, 1'b0, 1'b0, 10);

    // Back-to-back: cmd_valid stays high across the first command.
    d0 = done_cnt;
    bif.cmd_write = 1'b0; bif.cmd_lba = 32'd767; bif.cmd_count = 8'd1; bif.cmd_valid = 1'b1;
    n = 0;
    while (!bif.cmd_ready && n < 100) begin @(negedge clk); n++; end
    acc = cyc + 1;
    @(negedge clk);
    bif.cmd_lba = 32'd0;
    stream_read(32'd767, 256, -1, acc, lat, fw, lw, got);
    n = 0;
    while (!bif.cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("b2b_ready_with_done", 64'({bif.cmd_ready, done}), 64'(2'b11));
    chk("b2b_one_done", 64'(done_cnt - d0), 64'(1));
    acc = cyc + 1;
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_first_addr", {31'd0, ram_cs, ram_addr}, {31'd0, 1'b1, AddrW'(0)});
    d0 = done_cnt;
    stream_read(32'd0, 256, -1, acc, lat, fw, lw, got);
    chk("b2b_second_words", 64'(got), 64'(256));
    wait_done(d0);

    // Randomized commands against the reference image.
    for (int t = 0; t < 6; t++) begin
      lba = 32'($urandom_range(0, 769));
      cnt = 8'($urandom_range(1, 2));
      if (exp_reject(lba, cnt)) do_reject(lba, cnt);
      else if ($urandom_range(0, 1) == 1) do_write(lba, cnt, 1'b0, 1'b1, -1);
      else do_read(lba, cnt, $urandom_range(0, 300), lat, fw, lw);
    end
    do_read(32'd0, 8'd1, -1, lat, fw, lw);

    chk("no_ram_write_out_of_range", 64'(ram_oob), 64'(0));
    chk("cmd_ready_never_while_busy", 64'(bad_ready), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
